// File: rtl/spi_master_trx_char.sv
// SPI master transceiver: one 4..16-bit character per start, all four CPOL/CPHA modes.
// Define SPI_MASTER_LOOPBACK_EN to add S_LOOP, which samples the internal MOSI bit instead of MISO.
module spi_master_trx_char #(
    parameter int unsigned CHAR_NBITS = 16
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_REV,
    input  logic [3:0]            S_CHAR_LEN,
    input  logic [7:0]            S_DIV,
    input  logic                  S_CS_HOLD,
    input  logic                  S_START,
    input  logic [CHAR_NBITS-1:0] S_WCHAR,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  S_LOOP,
`endif
    output logic [CHAR_NBITS-1:0] S_RCHAR,
    output logic                  S_BUSY,
    output logic                  S_CHAR_DONE,
    output logic                  S_SPI_CS,
    output logic                  S_SPI_SCK,
    output logic                  S_SPI_MOSI,
    input  logic                  S_SPI_MISO
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e                  state_q;
    logic                    cpha_q, rev_q;
    logic [3:0]              last_q;
    logic [7:0]              div_q, cnt_q;
    logic [5:0]              edge_q;
    logic [CHAR_NBITS-1:0]   tx_q, rx_q, rchar_q;
    logic                    busy_q, done_q, cs_q, sck_q, mosi_q;

    logic [3:0] len_eff, pair, cur_idx, nxt_idx;
    logic [5:0] n_edges;
    logic       first_bit, leading, last_pair, sample_bit, edge_now;

    assign len_eff   = (S_CHAR_LEN < 4'd3) ? 4'd3 : S_CHAR_LEN;
    assign first_bit = S_REV ? S_WCHAR[len_eff] : S_WCHAR[0];

    // edge_q counts SCK edges already issued; each bit owns one leading/trailing pair
    assign pair      = edge_q[4:1];
    assign leading   = ~edge_q[0];
    assign cur_idx   = rev_q ? last_q - pair : pair;
    assign nxt_idx   = rev_q ? last_q - pair - 4'd1 : pair + 4'd1;
    assign last_pair = (pair == last_q);
    assign n_edges   = {1'b0, last_q, 1'b0} + 6'd2;
    assign edge_now  = (cnt_q == 8'd0) &&
                       ((state_q == StSetup) || ((state_q == StShift) && (edge_q != n_edges)));

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = S_LOOP ? mosi_q : S_SPI_MISO;
`else
    assign sample_bit = S_SPI_MISO;
`endif

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            state_q <= StIdle;
            cpha_q  <= 1'b0;
            rev_q   <= 1'b0;
            last_q  <= 4'd0;
            div_q   <= 8'd0;
            cnt_q   <= 8'd0;
            edge_q  <= 6'd0;
            tx_q    <= '0;
            rx_q    <= '0;
            rchar_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (!S_ENABLE) begin
                state_q <= StIdle;
                cs_q    <= 1'b1;
                sck_q   <= S_CPOL;
                mosi_q  <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        sck_q  <= S_CPOL;
                        mosi_q <= 1'b1;
                        busy_q <= 1'b0;
                        // the done cycle still counts as busy, so a start there is dropped
                        if (S_START && !done_q) begin
                            state_q <= StSetup;
                            cpha_q  <= S_CPHA;
                            rev_q   <= S_REV;
                            last_q  <= len_eff;
                            div_q   <= S_DIV;
                            cnt_q   <= S_DIV;
                            tx_q    <= S_WCHAR;
                            rx_q    <= '0;
                            edge_q  <= 6'd0;
                            cs_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            mosi_q  <= S_CPHA ? 1'b1 : first_bit;
                        end
                    end
                    StSetup: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            cnt_q   <= div_q;
                            state_q <= StShift;
                        end
                    end
                    StShift: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            cnt_q <= div_q;
                            if (edge_q == n_edges) state_q <= StHold;
                        end
                    end
                    StHold: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else begin
                            state_q <= StIdle;
                            rchar_q <= rx_q;
                            done_q  <= 1'b1;
                            cs_q    <= ~S_CS_HOLD;
                            mosi_q  <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase

                if (edge_now) begin
                    sck_q  <= ~sck_q;
                    edge_q <= edge_q + 6'd1;
                    if (leading) begin
                        if (cpha_q) mosi_q <= tx_q[cur_idx];
                        else        rx_q[cur_idx] <= sample_bit;
                    end else begin
                        if (cpha_q)          rx_q[cur_idx] <= sample_bit;
                        else if (!last_pair) mosi_q <= tx_q[nxt_idx];
                    end
                end
            end
        end
    end

    assign S_RCHAR     = rchar_q;
    assign S_BUSY      = busy_q;
    assign S_CHAR_DONE = done_q;
    assign S_SPI_CS    = cs_q;
    assign S_SPI_SCK   = sck_q;
    assign S_SPI_MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_master_trx_char.sv
// Directed bench for spi_master_trx_char: modes 0..3, latency, abort, start rejection, CS hold.
module tb_spi_master_trx_char;

    logic        S_SYSCLK = 1'b0;
    logic        S_RESETN = 1'b1;
    logic        S_ENABLE = 1'b0;
    logic        S_CPOL = 1'b0, S_CPHA = 1'b0, S_REV = 1'b1;
    logic [3:0]  S_CHAR_LEN = 4'd7;
    logic [7:0]  S_DIV = 8'd0;
    logic        S_CS_HOLD = 1'b0, S_START = 1'b0;
    logic [15:0] S_WCHAR = 16'h0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        S_LOOP = 1'b0;
`endif
    logic [15:0] S_RCHAR;
    logic        S_BUSY, S_CHAR_DONE, S_SPI_CS, S_SPI_SCK, S_SPI_MOSI, S_SPI_MISO;

    // 0: MISO tied to MOSI, 1: tied low, 2: slave model
    int          miso_sel = 0;
    logic        miso_slv = 1'b0;
    logic [15:0] slv_tx = 16'h0;
    logic [15:0] cap = 16'h0;
    logic [3:0]  slv_k = 4'd0;
    logic        prev_sck = 1'b0;
    logic        lead;
    int          cap_edges = 0, pulses = 0, n_done = 0, cs_rises = 0;
    int          total = 0, bad = 0;

    assign S_SPI_MISO = (miso_sel == 0) ? S_SPI_MOSI : (miso_sel == 1) ? 1'b0 : miso_slv;

    spi_master_trx_char #(.CHAR_NBITS(16)) dut (
        .S_SYSCLK    (S_SYSCLK),
        .S_RESETN    (S_RESETN),
        .S_ENABLE    (S_ENABLE),
        .S_CPOL      (S_CPOL),
        .S_CPHA      (S_CPHA),
        .S_REV       (S_REV),
        .S_CHAR_LEN  (S_CHAR_LEN),
        .S_DIV       (S_DIV),
        .S_CS_HOLD   (S_CS_HOLD),
        .S_START     (S_START),
        .S_WCHAR     (S_WCHAR),
`ifdef SPI_MASTER_LOOPBACK_EN
        .S_LOOP      (S_LOOP),
`endif
        .S_RCHAR     (S_RCHAR),
        .S_BUSY      (S_BUSY),
        .S_CHAR_DONE (S_CHAR_DONE),
        .S_SPI_CS    (S_SPI_CS),
        .S_SPI_SCK   (S_SPI_SCK),
        .S_SPI_MOSI  (S_SPI_MOSI),
        .S_SPI_MISO  (S_SPI_MISO)
    );

    always #5 S_SYSCLK = ~S_SYSCLK;

    // Pin-level slave: captures MOSI on its sample edge, drives MISO on leading edges (CPHA=1)
    always @(S_SPI_SCK or S_SPI_CS) begin
        if (S_SPI_CS !== 1'b0) begin
            slv_k = 4'd0;
        end else if (S_SPI_SCK !== prev_sck) begin
            lead = (S_SPI_SCK !== S_CPOL);
            cap_edges++;
            if (lead) pulses++;
            if (lead != S_CPHA) cap = S_REV ? {cap[14:0], S_SPI_MOSI} : {S_SPI_MOSI, cap[15:1]};
            if (lead && S_CPHA) begin
                miso_slv = slv_tx[slv_k];
                slv_k++;
            end
        end
        prev_sck = S_SPI_SCK;
    end

    always @(negedge S_SYSCLK) if (S_CHAR_DONE === 1'b1) n_done++;
    always @(posedge S_SPI_CS) cs_rises++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_SYSCLK);
        #1;
    endtask

    // returns in the cycle after the start was sampled (cycle 1)
    task automatic start_char(input logic [15:0] w);
        S_WCHAR = w;
        S_START = 1'b1;
        tick();
        S_START = 1'b0;
    endtask

    task automatic wait_done(input int from, input int limit, output int n);
        n = from;
        while (S_CHAR_DONE !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (S_CHAR_DONE !== 1'b1) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, b_done, b_pulses, b_edges, b_rises;

        #2 S_RESETN = 1'b0;
        #1;
        chk("rst_cs", S_SPI_CS, 1);
        chk("rst_sck", S_SPI_SCK, 0);
        chk("rst_mosi", S_SPI_MOSI, 1);
        chk("rst_rchar", S_RCHAR, 0);
        chk("rst_busy", S_BUSY, 0);
        chk("rst_done", S_CHAR_DONE, 0);
        repeat (3) @(posedge S_SYSCLK);
        #1 S_RESETN = 1'b1;
        S_ENABLE = 1'b1;
        tick();

        // Mode 0, MSB first, loopback through the pins
        S_CPOL = 0; S_CPHA = 0; S_REV = 1; S_CHAR_LEN = 7; S_DIV = 1; S_CS_HOLD = 0; miso_sel = 0;
        b_pulses = pulses;
        start_char(16'h00A5);
        chk("t1_cs_low", S_SPI_CS, 0);
        chk("t1_busy", S_BUSY, 1);
        chk("t1_first_mosi", S_SPI_MOSI, 1);
        wait_done(1, 200, n);
        chk("t1_latency", n, 37);
        chk("t1_rchar", S_RCHAR, 16'h00A5);
        chk("t1_mosi_bits", cap[7:0], 8'hA5);
        chk("t1_pulses", pulses - b_pulses, 8);
        chk("t1_cs_rise", S_SPI_CS, 1);
        chk("t1_mosi_idle", S_SPI_MOSI, 1);
        chk("t1_busy_done", S_BUSY, 1);
        tick();
        chk("t1_busy_after", S_BUSY, 0);
        chk("t1_done_pulse", S_CHAR_DONE, 0);

        // Mode 3, LSB first, 16 bits against the slave model
        S_CPOL = 1; S_CPHA = 1; S_REV = 0; S_CHAR_LEN = 15; S_DIV = 3; miso_sel = 2;
        slv_tx = 16'hBEEF;
        tick();
        b_pulses = pulses;
        start_char(16'h1234);
        wait_done(1, 400, n);
        chk("t2_latency", n, 137);
        chk("t2_rchar", S_RCHAR, 16'hBEEF);
        chk("t2_slave_cap", cap, 16'h1234);
        chk("t2_pulses", pulses - b_pulses, 16);
        tick();
        chk("t2_sck_idle", S_SPI_SCK, 1);

        // Mode 1, second start mid-transfer and in the done cycle are ignored
        S_CPOL = 0; S_CPHA = 1; S_REV = 1; S_CHAR_LEN = 7; S_DIV = 0; miso_sel = 0;
        tick();
        b_done = n_done;
        start_char(16'h005A);
        repeat (4) tick();
        S_WCHAR = 16'h00FF;
        S_START = 1'b1;
        tick();
        S_START = 1'b0;
        wait_done(6, 100, n);
        chk("t3_latency", n, 19);
        chk("t3_rchar", S_RCHAR, 16'h005A);
        S_START = 1'b1;
        tick();
        chk("t3_start_in_done", S_BUSY, 0);
        tick();
        chk("t3_start_next", S_BUSY, 1);
        S_START = 1'b0;
        S_ENABLE = 1'b0;
        tick();
        chk("t3_abort_busy", S_BUSY, 0);
        S_ENABLE = 1'b1;
        chk("t3_one_done", n_done - b_done, 1);

        // Mode 2, abort after five SCK edges
        S_CPOL = 1; S_CPHA = 0; S_REV = 1; S_CHAR_LEN = 7; S_DIV = 1; miso_sel = 0;
        tick();
        b_done = n_done;
        b_edges = cap_edges;
        start_char(16'h0096);
        t = 1;
        while (cap_edges - b_edges < 5 && t < 100) begin
            tick();
            t++;
        end
        chk("t4_edges", cap_edges - b_edges, 5);
        S_ENABLE = 1'b0;
        tick();
        chk("t4_cs", S_SPI_CS, 1);
        chk("t4_sck", S_SPI_SCK, 1);
        chk("t4_mosi", S_SPI_MOSI, 1);
        chk("t4_busy", S_BUSY, 0);
        chk("t4_done", S_CHAR_DONE, 0);
        chk("t4_rchar", S_RCHAR, 16'h005A);
        S_ENABLE = 1'b1;
        repeat (40) tick();
        chk("t4_no_done", n_done - b_done, 0);

        // CS held low across two characters
        S_CPOL = 0; S_CPHA = 0; S_REV = 1; S_CHAR_LEN = 7; S_DIV = 0; S_CS_HOLD = 1;
        tick();
        b_rises = cs_rises;
        start_char(16'h003C);
        wait_done(1, 100, n);
        chk("t5_latency1", n, 19);
        chk("t5_rchar1", S_RCHAR, 16'h003C);
        chk("t5_cs_held", S_SPI_CS, 0);
        repeat (3) tick();
        chk("t5_cs_idle_low", S_SPI_CS, 0);
        S_CS_HOLD = 0;
        start_char(16'h00C3);
        wait_done(1, 100, n);
        chk("t5_latency2", n, 19);
        chk("t5_rchar2", S_RCHAR, 16'h00C3);
        chk("t5_cs_rise", S_SPI_CS, 1);
        chk("t5_one_rise", cs_rises - b_rises, 1);

`ifdef SPI_MASTER_LOOPBACK_EN
        S_LOOP = 1'b1;
        miso_sel = 1;
        tick();
        start_char(16'h003C);
        wait_done(1, 100, n);
        chk("t6_loop_latency", n, 19);
        chk("t6_loop_rchar", S_RCHAR, 16'h003C);
        S_LOOP = 1'b0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
